// File: rtl/snake_key_cmd_queue_if.sv
// Turn-command handshake between the key queue and the game core.
// The queue drives valid/turn/count; the core answers with ready.
interface snake_key_cmd_queue_if #(
  parameter int CW = 3
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_turn;
  logic [CW-1:0] cmd_count;

  modport master (
    output cmd_valid,
    output cmd_turn,
    output cmd_count,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_turn,
    input  cmd_count,
    output cmd_ready
  );
endinterface

// File: rtl/snake_key_cmd_queue.sv
// Snake input side: sync + debounce two keys, queue turn commands
// in a small show-ahead FIFO popped by the game core on move ticks.
module snake_key_cmd_queue #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int DEPTH           = 4,
  parameter int CW              = $clog2(DEPTH + 1)
) (
  input  logic                         clockInp,
  input  logic                         resetInp_n,
  input  logic [1:0]                   KEY,
  input  logic                         clear,
  snake_key_cmd_queue_if.master        cmd,
  output logic                         overflow
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int AW = $clog2(DEPTH);
  localparam logic [DW-1:0] CNT_MAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [1:0]    sync1_q, sync1_d;
  logic [1:0]    sync2_q, sync2_d;
  logic [1:0]    stable_q, stable_d;
  logic [DW-1:0] cnt_q [2];
  logic [DW-1:0] cnt_d [2];
  logic [1:0]    press;

  logic          mem_q [DEPTH];
  logic          mem_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic push, push_turn, full, pop, do_push;

  // Stable levels start released so reset release never fires a press.
  always_comb begin
    sync1_d  = KEY;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    press    = '0;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = sync2_q[i];
          press[i]    = stable_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DW'(1);
        end
      end
    end
  end

  assign push      = |press;
  assign push_turn = ~press[0];
  assign full      = (count_q == FULL_CNT);
  assign pop       = cmd.cmd_valid & cmd.cmd_ready;
  assign do_push   = push & (~full | pop);

  always_comb begin
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = push_turn;
        wr_d        = wr_q + AW'(1);
      end
      if (pop) begin
        rd_d = rd_q + AW'(1);
      end
      unique case ({do_push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if ((push & ~do_push) | (&press)) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clockInp or negedge resetInp_n) begin
    if (!resetInp_n) begin
      sync1_q  <= 2'b11;
      sync2_q  <= 2'b11;
      stable_q <= 2'b11;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 1'b0;
      end
      rd_q     <= '0;
      wr_q     <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
      mem_q    <= mem_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign cmd.cmd_valid = (count_q != '0);
  assign cmd.cmd_turn  = mem_q[rd_q];
  assign cmd.cmd_count = count_q;
  assign overflow      = ovf_q;
endmodule
